count_window_monitor: RTL

- Downstream consumer of the 8-bit up/down counter's `count` bus.
- Samples `count` every enabled cycle and classifies it against a programmable window [lo, hi].
- Generates single-cycle enter/exit pulses and up/down wrap pulses, keeps a signed-modulo wrap tally, and flags a stalled counter.
- Shares `clk` and `clr` with the counter it observes.

---
 rtl/count_mon_pkg.sv | 13 +
 rtl/count_zone_classify.sv | 23 ++
 rtl/count_window_monitor.sv | 130 +++++++++++++
 3 files changed

// File: rtl/count_mon_pkg.sv
// Shared constants for the count window monitor: zone encodings and default sizes.
package count_mon_pkg;

    localparam logic [1:0] ZONE_INIT   = 2'b00;
    localparam logic [1:0] ZONE_BELOW  = 2'b01;
    localparam logic [1:0] ZONE_INSIDE = 2'b10;
    localparam logic [1:0] ZONE_ABOVE  = 2'b11;

    localparam int DEF_WIDTH      = 8;
    localparam int DEF_STALL_LIM  = 16;
    localparam int DEF_WRAP_CNT_W = 8;

endpackage

// File: rtl/count_zone_classify.sv
// Combinational classification of a count value against an inclusive [lo, hi] window.
module count_zone_classify
    import count_mon_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic [WIDTH-1:0] count,
    input  logic [WIDTH-1:0] lo,
    input  logic [WIDTH-1:0] hi,
    output logic [1:0]       zone_o
);

    // With lo > hi any count >= lo is also > hi, so an empty window falls out as ABOVE.
    always_comb begin
        zone_o = ZONE_ABOVE;
        if (count < lo) begin
            zone_o = ZONE_BELOW;
        end else if (count <= hi) begin
            zone_o = ZONE_INSIDE;
        end
    end

endmodule

// File: rtl/count_window_monitor.sv
// Watches an up/down counter bus: window zone FSM with enter/exit pulses,
// MAX<->0 wrap pulses with a signed-modulo tally, and stall detection.
module count_window_monitor
    import count_mon_pkg::*;
#(
    parameter int WIDTH      = DEF_WIDTH,
    parameter int STALL_LIM  = DEF_STALL_LIM,
    parameter int WRAP_CNT_W = DEF_WRAP_CNT_W
) (
    input  logic                  clk,
    input  logic                  clr,
    input  logic                  en,
    input  logic [WIDTH-1:0]      count,
    input  logic [WIDTH-1:0]      lo,
    input  logic [WIDTH-1:0]      hi,
    output logic [1:0]            zone,
    output logic                  in_window,
    output logic                  enter_p,
    output logic                  exit_p,
    output logic                  wrap_up_p,
    output logic                  wrap_dn_p,
    output logic [WRAP_CNT_W-1:0] wrap_cnt,
    output logic                  stalled
);

    localparam int SC_W = $clog2(STALL_LIM + 1);
    localparam logic [SC_W-1:0]  STALL_MAX = SC_W'(STALL_LIM);
    localparam logic [WIDTH-1:0] CNT_MAX   = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] CNT_ZERO  = '0;

    logic [1:0]            zone_q, zone_d;
    logic [WIDTH-1:0]      prev_q, prev_d;
    logic                  prev_valid_q, prev_valid_d;
    logic [SC_W-1:0]       stall_cnt_q, stall_cnt_d;
    logic                  stalled_q, stalled_d;
    logic [WRAP_CNT_W-1:0] wrap_cnt_q, wrap_cnt_d;
    logic                  enter_q, enter_d;
    logic                  exit_q, exit_d;
    logic                  wrap_up_q, wrap_up_d;
    logic                  wrap_dn_q, wrap_dn_d;
    logic [1:0]            cls_zone;

    count_zone_classify #(.WIDTH(WIDTH)) u_classify (
        .count  (count),
        .lo     (lo),
        .hi     (hi),
        .zone_o (cls_zone)
    );

    always_comb begin
        zone_d       = zone_q;
        prev_d       = prev_q;
        prev_valid_d = prev_valid_q;
        stall_cnt_d  = stall_cnt_q;
        stalled_d    = stalled_q;
        wrap_cnt_d   = wrap_cnt_q;
        enter_d      = 1'b0;
        exit_d       = 1'b0;
        wrap_up_d    = 1'b0;
        wrap_dn_d    = 1'b0;

        if (en) begin
            prev_d       = count;
            prev_valid_d = 1'b1;
            zone_d       = cls_zone;

            // The first sample after reset only seeds the zone; it never pulses.
            if (zone_q != ZONE_INIT) begin
                enter_d = (cls_zone == ZONE_INSIDE) && (zone_q != ZONE_INSIDE);
                exit_d  = (zone_q == ZONE_INSIDE) && (cls_zone != ZONE_INSIDE);
            end

            if (prev_valid_q) begin
                if ((prev_q == CNT_MAX) && (count == CNT_ZERO)) begin
                    wrap_up_d  = 1'b1;
                    wrap_cnt_d = wrap_cnt_q + WRAP_CNT_W'(1);
                end
                if ((prev_q == CNT_ZERO) && (count == CNT_MAX)) begin
                    wrap_dn_d  = 1'b1;
                    wrap_cnt_d = wrap_cnt_q - WRAP_CNT_W'(1);
                end

                if (count == prev_q) begin
                    stall_cnt_d = (stall_cnt_q == STALL_MAX) ? stall_cnt_q
                                                             : stall_cnt_q + SC_W'(1);
                    stalled_d   = (stall_cnt_d == STALL_MAX);
                end else begin
                    stall_cnt_d = '0;
                    stalled_d   = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            zone_q       <= ZONE_INIT;
            prev_q       <= '0;
            prev_valid_q <= 1'b0;
            stall_cnt_q  <= '0;
            stalled_q    <= 1'b0;
            wrap_cnt_q   <= '0;
            enter_q      <= 1'b0;
            exit_q       <= 1'b0;
            wrap_up_q    <= 1'b0;
            wrap_dn_q    <= 1'b0;
        end else begin
            zone_q       <= zone_d;
            prev_q       <= prev_d;
            prev_valid_q <= prev_valid_d;
            stall_cnt_q  <= stall_cnt_d;
            stalled_q    <= stalled_d;
            wrap_cnt_q   <= wrap_cnt_d;
            enter_q      <= enter_d;
            exit_q       <= exit_d;
            wrap_up_q    <= wrap_up_d;
            wrap_dn_q    <= wrap_dn_d;
        end
    end

    assign zone      = zone_q;
    assign in_window = (zone_q == ZONE_INSIDE);
    assign enter_p   = enter_q;
    assign exit_p    = exit_q;
    assign wrap_up_p = wrap_up_q;
    assign wrap_dn_p = wrap_dn_q;
    assign wrap_cnt  = wrap_cnt_q;
    assign stalled   = stalled_q;

endmodule
